spike_event_queue: RTL
======================

SPIKE_EVENT_QUEUE -- requirements
Module: spike_event_queue

Interface
REQ-001 Parameter NEURON_ID_W, default 4, width of the neuron identifier carried by each event.
REQ-002 Parameter TS_W, default 8, width of the timestep tag.
REQ-003 Parameter DEPTH, default 8, queue entries; power of two, >= 2.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 scan_start_en  input  1  scan-start pulse, same signal that drives the LIF stage; marks the timestep boundary.
REQ-007 spike_in  input  1  one-cycle spike pulse from the LIF stage.
REQ-008 spike_id_in  input  NEURON_ID_W  id of the firing neuron; valid when spike_in=1.
REQ-009 evt_valid  output  1  queue head holds an event.
REQ-010 evt_ready  input  1  consumer accepts head this cycle.
REQ-011 evt_id  output  NEURON_ID_W  head event neuron id.
REQ-012 evt_ts  output  TS_W  head event timestep tag.
REQ-013 count  output  log2(DEPTH)+1  current occupancy.
REQ-014 overflow  output  1  sticky flag: at least one spike dropped.
REQ-015 drop_cnt  output  8  saturating count of dropped spikes.
REQ-016 clr_overflow  input  1  synchronous clear of overflow and drop_cnt.

Function
REQ-017 Internal timestep counter ts SHALL increment by 1 on every cycle with scan_start_en=1, wrapping modulo 2^TS_W.
REQ-018 A spike SHALL be tagged with ts as registered before that cycle's increment (a spike coincident with scan_start_en belongs to the closing timestep).
REQ-019 Push: spike_in=1 and (count<DEPTH or pop in same cycle) SHALL write {spike_id_in, tag} at the write pointer.
REQ-020 Pop: evt_valid=1 and evt_ready=1 SHALL retire the head entry.
REQ-021 First-word fall-through: evt_valid SHALL equal (count!=0); evt_id/evt_ts SHALL be driven from the head entry with no extra register stage.
REQ-022 Latency: spike_in at edge N into an empty queue SHALL produce evt_valid=1 after edge N (visible in cycle N+1).
REQ-023 Simultaneous push and pop SHALL leave count unchanged, including when count=DEPTH (full) and when count=1.
REQ-024 Pop with evt_valid=0 SHALL be ignored; evt_ready has no effect when empty.
REQ-025 Drop: spike_in=1, count=DEPTH, no pop SHALL discard the spike, set overflow=1, increment drop_cnt saturating at 255.
REQ-026 Read/write pointers SHALL be log2(DEPTH) bits and wrap naturally; count SHALL distinguish full from empty.
REQ-027 clr_overflow=1 SHALL clear overflow and drop_cnt next edge; a drop in the same cycle wins: overflow=1, drop_cnt=1.
REQ-028 Head outputs SHALL remain stable while evt_valid=1 and evt_ready=0.

Reset
REQ-029 rst_n low SHALL asynchronously force: count=0, pointers=0, ts=0, evt_valid=0, overflow=0, drop_cnt=0; evt_id/evt_ts read as 0 while empty after reset.
REQ-030 Reset mid-operation SHALL discard all queued events; storage array contents need not be reset but SHALL never be presented with evt_valid=1.

Structure
REQ-031 Shared package SHALL hold the spike-event struct/field widths (NEURON_ID_W, TS_W) and the event packing order {id, ts}, reused by the LIF stage and event consumers.
REQ-032 One sub-module is natural: sync_fifo (parameterised width/depth, FWFT); the timestep counter and drop logic live in spike_event_queue.

Verification
REQ-033 Reset, then spike_in=1 id=5 with ts=0 -> next cycle evt_valid=1, evt_id=5, evt_ts=0, count=1.
REQ-034 Three scan_start_en pulses, then spike id=3 coincident with a fourth pulse -> event evt_ts=3; following spike id=4 -> evt_ts=4.
REQ-035 evt_ready=0, push 8 spikes ids 0..7, then 2 more -> count=8, overflow=1, drop_cnt=2; drain -> ids 0..7 in order.
REQ-036 Full queue, spike_in=1 id=9 with evt_ready=1 same cycle -> no drop, count stays 8, id 9 emerges last.
REQ-037 ts at 255 plus scan_start_en -> ts wraps to 0; clr_overflow coincident with a drop -> overflow=1, drop_cnt=1.
REQ-038 Queue holding 4 events, assert rst_n=0 mid-cycle -> evt_valid=0 immediately, count=0, ts=0.

Source files
------------

// File: rtl/spike_event_queue_pkg.sv
// Shared spike-event definitions: field widths and the {id, ts} packing order
// used by the LIF stage, this queue and downstream event consumers.
package spike_event_queue_pkg;

    localparam int NEURON_ID_W_DEF = 4;
    localparam int TS_W_DEF        = 8;
    localparam int DEPTH_DEF       = 8;
    localparam int DROP_CNT_W      = 8;

    // Neuron id sits in the upper bits, timestep tag in the lower bits.
    typedef struct packed {
        logic [NEURON_ID_W_DEF-1:0] id;
        logic [TS_W_DEF-1:0]        ts;
    } spike_evt_t;

    localparam int EVT_W_DEF = $bits(spike_evt_t);

endpackage

// File: rtl/spike_event_queue_fifo.sv
// First-word fall-through synchronous FIFO; a push into a full FIFO is accepted
// only when the head is popped in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       ready,
    output logic                       valid,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       push_ok
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop;
    logic             full;

    always_comb begin
        full     = (count_q == CNT_W'(DEPTH));
        pop      = (count_q != '0) && ready;
        push_ok  = push && (!full || pop);
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push_ok) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the count gate below keeps stale words hidden.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign valid = (count_q != '0);
    assign rdata = valid ? mem_q[rd_ptr_q] : '0;
    assign count = count_q;

endmodule

// File: rtl/spike_event_queue.sv
// Timestep-tagged spike event queue: stamps LIF spikes with the current
// timestep, buffers them in a FWFT FIFO and tracks dropped spikes.
module spike_event_queue
    import spike_event_queue_pkg::*;
#(
    parameter int NEURON_ID_W = NEURON_ID_W_DEF,
    parameter int TS_W        = TS_W_DEF,
    parameter int DEPTH       = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     scan_start_en,
    input  logic                     spike_in,
    input  logic [NEURON_ID_W-1:0]   spike_id_in,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [NEURON_ID_W-1:0]   evt_id,
    output logic [TS_W-1:0]          evt_ts,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [DROP_CNT_W-1:0]    drop_cnt,
    input  logic                     clr_overflow
);

    localparam int EVT_W = NEURON_ID_W + TS_W;

    logic [TS_W-1:0]       ts_q, ts_d;
    logic                  overflow_q, overflow_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [EVT_W-1:0]      head;
    logic                  push_ok;
    logic                  drop;

    // Tag uses ts before this cycle's increment, so a spike coincident with
    // scan_start_en belongs to the timestep that is closing.
    sync_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (spike_in),
        .wdata   ({spike_id_in, ts_q}),
        .ready   (evt_ready),
        .valid   (evt_valid),
        .rdata   (head),
        .count   (count),
        .push_ok (push_ok)
    );

    always_comb begin
        drop       = spike_in && !push_ok;
        ts_d       = scan_start_en ? ts_q + TS_W'(1) : ts_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (clr_overflow) begin
                drop_cnt_d = DROP_CNT_W'(1);
            end else if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
            end
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q       <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            ts_q       <= ts_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign evt_id   = head[EVT_W-1:TS_W];
    assign evt_ts   = head[TS_W-1:0];
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

endmodule
